// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported SRAM with a fixed
// access time of WAIT_CYCLES clocks per transfer.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic [15:0] Mem_addr,
    output logic [15:0] Mem_wdata,
    input  logic [15:0] Mem_rdata,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic        Mem_drive,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        grant_q, grant_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_oe_q, mem_oe_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_drive_q, mem_drive_d;
    logic        busy_q, busy_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        sel_s;
    logic        sel_we_s;

    // Next-state and next-output computation for the arbiter FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_oe_d    = mem_oe_q;
        mem_we_d    = mem_we_q;
        mem_drive_d = mem_drive_q;
        busy_d      = busy_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        sel_s       = 1'b0;
        sel_we_s    = 1'b0;

        case (state_q)
            IDLE: begin
                mem_oe_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_drive_d = 1'b0;
                busy_d      = 1'b0;
                if (req0 || req1) begin
                    // On a tie the port not served last wins
                    if (req0 && req1) begin
                        sel_s = ~grant_q;
                    end else begin
                        sel_s = req1;
                    end
                    sel_we_s    = sel_s ? we1 : we0;
                    grant_d     = sel_s;
                    wr_d        = sel_we_s;
                    mem_addr_d  = sel_s ? addr1 : addr0;
                    mem_wdata_d = sel_s ? wdata1 : wdata0;
                    cnt_d       = CNT_LOAD;
                    busy_d      = 1'b1;
                    mem_oe_d    = ~sel_we_s;
                    mem_we_d    = sel_we_s;
                    mem_drive_d = sel_we_s;
                    state_d     = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    mem_oe_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_drive_d = 1'b0;
                    ack0_d      = ~grant_q;
                    ack1_d      = grant_q;
                    state_d     = DONE;
                    if (!wr_q) begin
                        rdata_d = Mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_oe_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_drive_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            grant_q     <= 1'b1;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            rdata_q     <= 16'h0000;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_drive_q <= 1'b0;
            busy_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            mem_drive_q <= mem_drive_d;
            busy_q      <= busy_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign Mem_addr  = mem_addr_q;
    assign Mem_wdata = mem_wdata_q;
    assign Mem_OE    = mem_oe_q;
    assign Mem_WE    = mem_we_q;
    assign Mem_drive = mem_drive_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=2 and one
// with WAIT_CYCLES=1, sharing clock, reset and SRAM read data.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = 16'h0, addr1 = 16'h0, wdata0 = 16'h0, wdata1 = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    logic        ack0, ack1, mem_oe, mem_we, mem_drive, busy, grant;
    logic [15:0] rdata, mem_addr, mem_wdata;

    logic        req0_b = 1'b0;
    logic [15:0] addr0_b = 16'h0;
    logic        ack0_b, ack1_b, mem_oe_b, mem_we_b, mem_drive_b, busy_b, grant_b;
    logic [15:0] rdata_b, mem_addr_b, mem_wdata_b;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 Clk = ~Clk;

    mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .Mem_addr(mem_addr), .Mem_wdata(mem_wdata), .Mem_rdata(mem_rdata),
        .Mem_OE(mem_oe), .Mem_WE(mem_we), .Mem_drive(mem_drive),
        .busy(busy), .grant(grant)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .req0(req0_b), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(addr0_b), .addr1(16'h0000), .wdata0(16'h0000), .wdata1(16'h0000),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
        .Mem_addr(mem_addr_b), .Mem_wdata(mem_wdata_b), .Mem_rdata(mem_rdata),
        .Mem_OE(mem_oe_b), .Mem_WE(mem_we_b), .Mem_drive(mem_drive_b),
        .busy(busy_b), .grant(grant_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        Reset = 1'b0;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_ack",   32'({ack0, ack1}), 32'd0);
        check("rst_strb",  32'({mem_oe, mem_we, mem_drive}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h0000);
        check("rst_addr",  32'(mem_addr), 32'h0000);
        check("rst_wdata", 32'(mem_wdata), 32'h0000);
        check("rst_w1",    32'({busy_b, ack0_b, mem_oe_b, grant_b}), 32'b0001);

        // Read on port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h3000; mem_rdata = 16'h1234;
        tick();
        check("rd_c1_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b100);
        check("rd_c1_busy", 32'(busy), 32'd1);
        check("rd_c1_addr", 32'(mem_addr), 32'h3000);
        check("rd_c1_grnt", 32'(grant), 32'd0);
        check("rd_c1_ack",  32'(ack0), 32'd0);
        tick();
        check("rd_c2_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b100);
        check("rd_c2_ack",  32'(ack0), 32'd0);
        tick();
        check("rd_c3_ack",  32'({ack0, ack1}), 32'b10);
        check("rd_c3_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b000);
        check("rd_c3_rdat", 32'(rdata), 32'h1234);
        check("rd_c3_busy", 32'(busy), 32'd1);
        check("rd_c3_addr", 32'(mem_addr), 32'h3000);
        req0 = 1'b0;
        tick();
        check("rd_c4_ack",  32'(ack0), 32'd0);
        check("rd_c4_busy", 32'(busy), 32'd0);
        check("rd_c4_rdat", 32'(rdata), 32'h1234);

        // Write on port 1; read data must stay untouched
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00FF; wdata1 = 16'hBEEF; mem_rdata = 16'h5555;
        tick();
        check("wr_c1_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b011);
        check("wr_c1_addr", 32'(mem_addr), 32'h00FF);
        check("wr_c1_wdat", 32'(mem_wdata), 32'hBEEF);
        check("wr_c1_grnt", 32'(grant), 32'd1);
        tick();
        check("wr_c2_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b011);
        check("wr_c2_ack",  32'({ack0, ack1}), 32'b00);
        tick();
        check("wr_c3_ack",  32'({ack0, ack1}), 32'b01);
        check("wr_c3_strb", 32'({mem_oe, mem_we, mem_drive}), 32'b000);
        check("wr_c3_rdat", 32'(rdata), 32'h1234);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        check("wr_c4_ack",  32'({ack0, ack1}), 32'b00);
        check("wr_c4_busy", 32'(busy), 32'd0);

        // Tie after reset: strict alternation starting at port 0
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0A00; addr1 = 16'h0B00;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("tie_grant", 32'(grant), 32'(t % 2));
            check("tie_addr",  32'(mem_addr), (t % 2 == 0) ? 32'h0A00 : 32'h0B00);
            tick();
            check("tie_noack", 32'({ack0, ack1}), 32'b00);
            tick();
            check("tie_ack",   32'({ack0, ack1}), (t % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            check("tie_idle",  32'({ack0, ack1, busy}), 32'b000);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Reset in the second ACCESS cycle aborts the read
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h3000; mem_rdata = 16'h1234;
        tick();
        tick();
        check("ab_c2_oe", 32'(mem_oe), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0; req0 = 1'b0;
        check("ab_strb",  32'({mem_oe, mem_we, mem_drive}), 32'b000);
        check("ab_busy",  32'(busy), 32'd0);
        check("ab_ack",   32'(ack0), 32'd0);
        check("ab_rdata", 32'(rdata), 32'h0000);
        tick();
        check("ab_noack", 32'({ack0, busy}), 32'b00);

        // WAIT_CYCLES=1, request dropped during ACCESS
        req0_b = 1'b1; addr0_b = 16'h0001; mem_rdata = 16'hCAFE;
        tick();
        req0_b = 1'b0;
        check("w1_c1_oe",   32'({mem_oe_b, mem_we_b, mem_drive_b}), 32'b100);
        check("w1_c1_addr", 32'(mem_addr_b), 32'h0001);
        check("w1_c1_ack",  32'(ack0_b), 32'd0);
        tick();
        check("w1_c2_ack",  32'({ack0_b, ack1_b}), 32'b10);
        check("w1_c2_oe",   32'(mem_oe_b), 32'd0);
        check("w1_c2_rdat", 32'(rdata_b), 32'hCAFE);
        tick();
        check("w1_c3_ack",  32'({ack0_b, busy_b}), 32'b00);
        tick();
        check("w1_c4_idle", 32'({busy_b, mem_oe_b}), 32'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 2, SRAM access cycles per transfer (legal range 1..15).
REQ-002 SHALL have port: Clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0/req1  in  1  request from port 0 (CPU) / port 1 (IO/DMA).
REQ-005 SHALL have ports: we0/we1  in  1  1=write, 0=read, sampled with request.
REQ-006 SHALL have ports: addr0/addr1  in  16  word address; wdata0/wdata1  in  16  write data.
REQ-007 SHALL have ports: ack0/ack1  out  1  one-cycle completion pulse to the granted port.
REQ-008 SHALL have port: rdata  out  16  read data, valid in the ack cycle and held until the next read completes.
REQ-009 SHALL have ports: Mem_addr  out  16; Mem_wdata  out  16; Mem_rdata  in  16.
REQ-010 SHALL have ports: Mem_OE  out  1; Mem_WE  out  1; Mem_drive  out  1; all active-high (Mem_drive enables the write-data bus driver).
REQ-011 SHALL have ports: busy  out  1  transaction in progress; grant  out  1  port owning the current or last transaction.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-013 In IDLE with no request, SHALL remain in IDLE with Mem_OE=Mem_WE=Mem_drive=0 and busy=0.
REQ-014 In IDLE with exactly one request, SHALL grant that port.
REQ-015 In IDLE with both requests, SHALL grant the port not granted last (round-robin); reset makes port 0 win the first tie.
REQ-016 On grant, SHALL register addr, we, and wdata of the winner plus the grant bit, load the wait counter with WAIT_CYCLES-1, and enter ACCESS.
REQ-017 Inputs of either port SHALL be ignored outside the IDLE sampling cycle.
REQ-018 In ACCESS, SHALL drive Mem_addr from the register and assert busy=1.
- Read: Mem_OE=1, Mem_WE=0, Mem_drive=0.
- Write: Mem_WE=1, Mem_drive=1, Mem_OE=0.
REQ-019 ACCESS SHALL last exactly WAIT_CYCLES cycles.
- Counter decrements each cycle; on counter=0, go to DONE.
- On a read, capture Mem_rdata into rdata at that edge.
REQ-020 In DONE, SHALL pulse ack of the granted port for exactly one cycle, with Mem_OE=Mem_WE=Mem_drive=0, busy=1, Mem_addr held; next state IDLE unconditionally.
REQ-021 SHALL give latency of WAIT_CYCLES+1 cycles from the IDLE sampling edge to the ack cycle; back-to-back transactions take WAIT_CYCLES+2 cycles each.
REQ-022 Requester SHALL hold req and operands until ack, then deassert by the following edge; a req still high in the IDLE cycle after DONE starts a new transaction.
REQ-023 If req drops during ACCESS, the transfer SHALL complete and ack SHALL still pulse.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle; Mem_OE and Mem_WE SHALL never be high in the same cycle.
REQ-025 rdata SHALL NOT change on write transactions.

Reset
REQ-026 Reset SHALL force state IDLE, grant=1 (last-served=port 1), counter=0, and the following outputs to 0: ack0, ack1, Mem_OE, Mem_WE, Mem_drive, busy, rdata, Mem_addr, Mem_wdata.
REQ-027 Reset during ACCESS or DONE SHALL abort the transaction with no ack issued; strobes SHALL be 0 from the cycle after the reset edge.

Verification
REQ-028 Read, WAIT_CYCLES=2: req0=1, we0=0, addr0=0x3000, Mem_rdata=0x1234 -> Mem_OE high 2 cycles, ack0 pulses 3 cycles after sample, rdata=0x1234.
REQ-029 Write, WAIT_CYCLES=2: req1=1, we1=1, addr1=0x00FF, wdata1=0xBEEF -> Mem_WE=Mem_drive=1 for 2 cycles, Mem_wdata=0xBEEF, Mem_addr=0x00FF, ack1 once, rdata unchanged.
REQ-030 Tie after reset: req0=req1=1 held across acks -> order port0, port1, port0, port1; each ack one cycle, never overlapping.
REQ-031 Reset asserted in second ACCESS cycle of a read -> no ack0, Mem_OE=0 next cycle, busy=0, rdata=0x0000.
REQ-032 WAIT_CYCLES=1: req0 read at 0x0001 -> Mem_OE high 1 cycle, ack0 in cycle 2 after sample; req0 dropped mid-ACCESS still yields ack0.
